// File: rtl/logic_axi4_stream_packet_arbiter_if.sv
// AXI4-Stream bundle used by every rx requester and by the shared tx output of the packet arbiter.
interface logic_axi4_stream_if #(
   parameter int TDATA_BYTES = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TID_WIDTH   = 1
);
   logic                       tvalid;
   logic                       tready;
   logic [TDATA_BYTES*8-1:0]   tdata;
   logic [TDATA_BYTES-1:0]     tkeep;
   logic [TDATA_BYTES-1:0]     tstrb;
   logic                       tlast;
   logic [TUSER_WIDTH-1:0]     tuser;
   logic [TDEST_WIDTH-1:0]     tdest;
   logic [TID_WIDTH-1:0]       tid;

   modport tx     (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
   modport rx     (input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
   modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
   modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream datapath between INPUTS requesters,
// with a single fully registered output stage.
module logic_axi4_stream_packet_arbiter #(
   parameter int INPUTS      = 2,
   parameter int TDATA_BYTES = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TID_WIDTH   = 1,
   parameter bit USE_TLAST   = 1'b1,
   parameter bit USE_TKEEP   = 1'b1,
   parameter bit USE_TSTRB   = 1'b1,
   localparam int SEL_W      = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
   input  logic             aclk,
   input  logic             areset_n,
   logic_axi4_stream_if.rx  rx [INPUTS],
   logic_axi4_stream_if.tx  tx,
   output logic [SEL_W-1:0] grant
);

   localparam int DATA_W = TDATA_BYTES * 8;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state;
   logic [SEL_W-1:0]       lock_idx;
   logic [SEL_W-1:0]       ptr;

   logic                   rx_valid [INPUTS];
   logic [DATA_W-1:0]      rx_data  [INPUTS];
   logic [TDATA_BYTES-1:0] rx_keep  [INPUTS];
   logic [TDATA_BYTES-1:0] rx_strb  [INPUTS];
   logic                   rx_last  [INPUTS];
   logic [TUSER_WIDTH-1:0] rx_user  [INPUTS];
   logic [TDEST_WIDTH-1:0] rx_dest  [INPUTS];
   logic [TID_WIDTH-1:0]   rx_id    [INPUTS];

   logic                   tvalid_q;
   logic [DATA_W-1:0]      tdata_q;
   logic [TDATA_BYTES-1:0] tkeep_q;
   logic [TDATA_BYTES-1:0] tstrb_q;
   logic                   tlast_q;
   logic [TUSER_WIDTH-1:0] tuser_q;
   logic [TDEST_WIDTH-1:0] tdest_q;
   logic [TID_WIDTH-1:0]   tid_q;

   logic                   load;
   logic [SEL_W-1:0]       scan_sel;
   logic [SEL_W-1:0]       sel;
   logic [SEL_W-1:0]       sel_next;
   logic                   accept;

   // Flatten the interface array so the selected source can be muxed by a run-time index.
   for (genvar i = 0; i < INPUTS; i++) begin : g_rx
      assign rx_valid[i]  = rx[i].tvalid;
      assign rx_data[i]   = rx[i].tdata;
      assign rx_keep[i]   = rx[i].tkeep;
      assign rx_strb[i]   = rx[i].tstrb;
      assign rx_last[i]   = rx[i].tlast;
      assign rx_user[i]   = rx[i].tuser;
      assign rx_dest[i]   = rx[i].tdest;
      assign rx_id[i]     = rx[i].tid;
      assign rx[i].tready = load && (sel == SEL_W'(i));
   end

   assign load = !tvalid_q || tx.tready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin : scan
      int j;
      scan_sel = ptr;
      for (int k = INPUTS - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % INPUTS;
         if (rx_valid[j]) scan_sel = SEL_W'(j);
      end
   end

   assign sel      = (state == LOCKED) ? lock_idx : scan_sel;
   assign sel_next = (sel == SEL_W'(INPUTS - 1)) ? '0 : sel + 1'b1;
   assign accept   = load && rx_valid[sel];

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state    <= IDLE;
         lock_idx <= '0;
         ptr      <= '0;
         grant    <= '0;
         tvalid_q <= 1'b0;
         // NOTE: payload registers are reset as well so tx is fully defined out of reset.
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tstrb_q  <= '0;
         tlast_q  <= 1'b0;
         tuser_q  <= '0;
         tdest_q  <= '0;
         tid_q    <= '0;
      end else begin
         if (load) tvalid_q <= accept;
         if (accept) begin
            tdata_q <= rx_data[sel];
            tkeep_q <= rx_keep[sel];
            tstrb_q <= rx_strb[sel];
            tlast_q <= rx_last[sel];
            tuser_q <= rx_user[sel];
            tdest_q <= rx_dest[sel];
            tid_q   <= rx_id[sel];
            grant   <= sel;
            if (USE_TLAST && !rx_last[sel]) begin
               state    <= LOCKED;
               lock_idx <= sel;
            end else begin
               state <= IDLE;
               ptr   <= sel_next;
            end
         end
      end
   end

   assign tx.tvalid = tvalid_q;
   assign tx.tdata  = tdata_q;
   assign tx.tkeep  = USE_TKEEP ? tkeep_q : '1;
   assign tx.tstrb  = USE_TSTRB ? tstrb_q : '1;
   assign tx.tlast  = USE_TLAST ? tlast_q : 1'b1;
   assign tx.tuser  = tuser_q;
   assign tx.tdest  = tdest_q;
   assign tx.tid    = tid_q;

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Directed bench for the packet arbiter: three instances (2 inputs, 4 inputs, 2 inputs without tlast)
// driven by one shared source model, with hand-computed expected beat sequences.
`timescale 1ns/1ps
module tb_logic_axi4_stream_packet_arbiter;

   logic clk;
   logic areset_n;
   logic tx_ready;
   int   act;

   int   n_checks;
   int   n_fail;

   // Source model: each source emits data = src*16 + seq in packets of s_len beats.
   bit   s_en   [4];
   int   s_len  [4];
   int   s_beat [4];
   int   s_seq  [4];
   int   s_left [4];
   logic       s_vld [4];
   logic [7:0] s_dat [4];
   logic       s_lst [4];
   logic       s_rdy [4];

   logic       o_vld;
   logic [7:0] o_dat;
   logic       o_lst;
   int         o_gnt;

   logic [7:0] cap_dat [$];
   logic       cap_lst [$];
   int         cap_gnt [$];
   int         cap_cyc [$];
   int         cyc;
   int         first_acc;

   logic [0:0] gnt_a;
   logic [1:0] gnt_b;
   logic [0:0] gnt_c;

   logic_axi4_stream_if #(.TDATA_BYTES(1)) rx_a [2] ();
   logic_axi4_stream_if #(.TDATA_BYTES(1)) tx_a ();
   logic_axi4_stream_if #(.TDATA_BYTES(1)) rx_b [4] ();
   logic_axi4_stream_if #(.TDATA_BYTES(1)) tx_b ();
   logic_axi4_stream_if #(.TDATA_BYTES(1)) rx_c [2] ();
   logic_axi4_stream_if #(.TDATA_BYTES(1)) tx_c ();

   logic_axi4_stream_packet_arbiter #(.INPUTS(2), .USE_TLAST(1'b1)) dut_a (
      .aclk(clk), .areset_n(areset_n), .rx(rx_a), .tx(tx_a), .grant(gnt_a));
   logic_axi4_stream_packet_arbiter #(.INPUTS(4), .USE_TLAST(1'b1)) dut_b (
      .aclk(clk), .areset_n(areset_n), .rx(rx_b), .tx(tx_b), .grant(gnt_b));
   logic_axi4_stream_packet_arbiter #(.INPUTS(2), .USE_TLAST(1'b0)) dut_c (
      .aclk(clk), .areset_n(areset_n), .rx(rx_c), .tx(tx_c), .grant(gnt_c));

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         s_vld[i] = s_en[i] && (s_left[i] > 0);
         s_dat[i] = 8'(i * 16 + s_seq[i]);
         s_lst[i] = (s_beat[i] == s_len[i] - 1);
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_a
      assign rx_a[i].tvalid = (act == 0) && s_vld[i];
      assign rx_a[i].tdata  = s_dat[i];
      assign rx_a[i].tlast  = s_lst[i];
      assign rx_a[i].tkeep  = '1;
      assign rx_a[i].tstrb  = '1;
      assign rx_a[i].tuser  = '0;
      assign rx_a[i].tdest  = '0;
      assign rx_a[i].tid    = '0;
      assign rx_c[i].tvalid = (act == 2) && s_vld[i];
      assign rx_c[i].tdata  = s_dat[i];
      assign rx_c[i].tlast  = s_lst[i];
      assign rx_c[i].tkeep  = '1;
      assign rx_c[i].tstrb  = '1;
      assign rx_c[i].tuser  = '0;
      assign rx_c[i].tdest  = '0;
      assign rx_c[i].tid    = '0;
   end

   for (genvar i = 0; i < 4; i++) begin : g_b
      assign rx_b[i].tvalid = (act == 1) && s_vld[i];
      assign rx_b[i].tdata  = s_dat[i];
      assign rx_b[i].tlast  = s_lst[i];
      assign rx_b[i].tkeep  = '1;
      assign rx_b[i].tstrb  = '1;
      assign rx_b[i].tuser  = '0;
      assign rx_b[i].tdest  = '0;
      assign rx_b[i].tid    = '0;
   end

   assign tx_a.tready = tx_ready;
   assign tx_b.tready = tx_ready;
   assign tx_c.tready = tx_ready;

   always_comb begin
      for (int i = 0; i < 4; i++) s_rdy[i] = 1'b0;
      o_vld = 1'b0;
      o_dat = '0;
      o_lst = 1'b0;
      o_gnt = 0;
      case (act)
         0: begin
            s_rdy[0] = rx_a[0].tready;
            s_rdy[1] = rx_a[1].tready;
            o_vld = tx_a.tvalid; o_dat = tx_a.tdata; o_lst = tx_a.tlast; o_gnt = int'(gnt_a);
         end
         1: begin
            s_rdy[0] = rx_b[0].tready;
            s_rdy[1] = rx_b[1].tready;
            s_rdy[2] = rx_b[2].tready;
            s_rdy[3] = rx_b[3].tready;
            o_vld = tx_b.tvalid; o_dat = tx_b.tdata; o_lst = tx_b.tlast; o_gnt = int'(gnt_b);
         end
         default: begin
            s_rdy[0] = rx_c[0].tready;
            s_rdy[1] = rx_c[1].tready;
            o_vld = tx_c.tvalid; o_dat = tx_c.tdata; o_lst = tx_c.tlast; o_gnt = int'(gnt_c);
         end
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < 4; i++) begin
         s_en[i] = 1'b0; s_len[i] = 1; s_beat[i] = 0; s_seq[i] = 0; s_left[i] = 0;
      end
      cap_dat.delete(); cap_lst.delete(); cap_gnt.delete(); cap_cyc.delete();
      cyc = 0;
      first_acc = -1;
   endtask

   // One clock: sample handshakes and tx at the falling edge, advance sources just after the rising edge.
   task automatic cycle();
      bit acc [4];
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = s_vld[i] && s_rdy[i];
      if (o_vld && tx_ready) begin
         cap_dat.push_back(o_dat);
         cap_lst.push_back(o_lst);
         cap_gnt.push_back(o_gnt);
         cap_cyc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) if (acc[i] && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i]) begin
            s_seq[i]++;
            s_left[i]--;
            s_beat[i] = (s_beat[i] == s_len[i] - 1) ? 0 : s_beat[i] + 1;
         end
      end
      cyc++;
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (cap_dat.size() < n && k < budget) begin
         cycle();
         k++;
      end
      check(tag, cap_dat.size(), n);
   endtask

   task automatic wait_seq(input string tag, input int src, input int n, input int budget);
      int k;
      k = 0;
      while (s_seq[src] < n && k < budget) begin
         cycle();
         k++;
      end
      check(tag, s_seq[src], n);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      act      = 0;
      tx_ready = 1'b1;
      areset_n = 1'b0;
      clear_sources();

      // Reset state
      #3;
      check("rst_tvalid", o_vld, 0);
      check("rst_grant", o_gnt, 0);
      check("rst_tdata", o_dat, 0);
      check("rst_tlast", o_lst, 0);
      check("rst_b_tvalid", tx_b.tvalid, 0);
      #9 areset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: two 3-beat packets, rx0 first, contiguous, one-cycle latency
      s_len[0] = 3; s_len[1] = 3; s_left[0] = 3; s_left[1] = 3;
      s_en[0] = 1'b1; s_en[1] = 1'b1;
      #1;
      check("t1_rdy0", s_rdy[0], 1);
      check("t1_rdy1", s_rdy[1], 0);
      run_until("t1_count", 6, 30);
      check("t1_latency", cap_cyc[0], first_acc + 1);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t1_data%0d", k), cap_dat[k], (k < 3) ? k : 16 + k - 3);
         check($sformatf("t1_grant%0d", k), cap_gnt[k], (k < 3) ? 0 : 1);
         check($sformatf("t1_last%0d", k), cap_lst[k], (k % 3 == 2) ? 1 : 0);
         check($sformatf("t1_cyc%0d", k), cap_cyc[k], cap_cyc[0] + k);
      end
      repeat (2) cycle();

      // 3: rx0 stalls mid-packet for 5 cycles, rx1 stays locked out
      clear_sources();
      s_len[0] = 4; s_len[1] = 4; s_left[0] = 4; s_left[1] = 4;
      s_en[0] = 1'b1; s_en[1] = 1'b1;
      wait_seq("t3_start", 0, 2, 20);
      s_en[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t3_rdy1_%0d", k), s_rdy[1], 0);
         cycle();
      end
      check("t3_rx1_seq", s_seq[1], 0);
      s_en[0] = 1'b1;
      run_until("t3_count", 8, 40);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t3_data%0d", k), cap_dat[k], (k < 4) ? k : 16 + k - 4);
         check($sformatf("t3_grant%0d", k), cap_gnt[k], (k < 4) ? 0 : 1);
      end
      repeat (2) cycle();

      // 4: tx.tready low for 4 cycles during a packet
      clear_sources();
      s_len[0] = 4; s_left[0] = 4; s_en[0] = 1'b1;
      run_until("t4_start", 2, 20);
      tx_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check($sformatf("t4_vld%0d", k), o_vld, 1);
         check($sformatf("t4_dat%0d", k), o_dat, 8'h02);
         check($sformatf("t4_lst%0d", k), o_lst, 0);
         check($sformatf("t4_gnt%0d", k), o_gnt, 0);
         check($sformatf("t4_rdy%0d", k), s_rdy[0], 0);
      end
      check("t4_hold_seq", s_seq[0], 3);
      tx_ready = 1'b1;
      run_until("t4_count", 4, 20);
      repeat (3) cycle();
      check("t4_total", cap_dat.size(), 4);
      for (int k = 0; k < 4; k++) check($sformatf("t4_data%0d", k), cap_dat[k], k);
      check("t4_last", cap_lst[3], 1);

      // 5: reset pulse in the middle of a 4-beat rx1 packet
      clear_sources();
      s_len[1] = 4; s_left[1] = 4; s_en[1] = 1'b1;
      wait_seq("t5_start", 1, 2, 20);
      s_len[0] = 1; s_left[0] = 1; s_en[0] = 1'b1;
      #1;
      check("t5_locked_rdy0", s_rdy[0], 0);
      areset_n = 1'b0;
      #1;
      check("t5_async_tvalid", o_vld, 0);
      check("t5_async_grant", o_gnt, 0);
      areset_n = 1'b1;
      s_beat[1] = 0; s_seq[1] = 0; s_left[1] = 4;
      #1;
      check("t5_rdy0", s_rdy[0], 1);
      check("t5_rdy1", s_rdy[1], 0);
      cap_dat.delete(); cap_lst.delete(); cap_gnt.delete(); cap_cyc.delete();
      run_until("t5_count", 5, 30);
      check("t5_first_grant", cap_gnt[0], 0);
      check("t5_first_data", cap_dat[0], 8'h00);
      for (int k = 1; k < 5; k++) begin
         check($sformatf("t5_data%0d", k), cap_dat[k], 16 + k - 1);
         check($sformatf("t5_grant%0d", k), cap_gnt[k], 1);
      end
      repeat (2) cycle();

      // 2: four sources, continuous single-beat packets
      clear_sources();
      act = 1;
      for (int i = 0; i < 4; i++) begin
         s_len[i] = 1; s_left[i] = 3; s_en[i] = 1'b1;
      end
      run_until("t2_count", 12, 40);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("t2_grant%0d", k), cap_gnt[k], k % 4);
         check($sformatf("t2_data%0d", k), cap_dat[k], (k % 4) * 16 + k / 4);
      end
      check("t2_no_gaps", cap_cyc[11] - cap_cyc[0], 11);
      repeat (2) cycle();

      // 6: no-tlast instance alternates per beat, tx.tlast forced high
      clear_sources();
      act = 2;
      s_len[0] = 3; s_len[1] = 3; s_left[0] = 4; s_left[1] = 4;
      s_en[0] = 1'b1; s_en[1] = 1'b1;
      run_until("t6_count", 8, 40);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t6_grant%0d", k), cap_gnt[k], k % 2);
         check($sformatf("t6_data%0d", k), cap_dat[k], (k % 2) * 16 + k / 2);
         check($sformatf("t6_last%0d", k), cap_lst[k], 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
